// File: rtl/pe_array_1d_ctrl_pkg.sv
// Shared types and constants for the 1-D systolic PE array sequencer.
package pe_array_pkg;

    localparam int          DATA_WIDTH = 16;
    localparam int          MAX_TAPS   = 5;
    localparam logic [15:0] ONE        = 16'h3C00;
    localparam logic [15:0] ZERO       = 16'h0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    // Filter and stride must both fall in 1..MAX_TAPS.
    function automatic logic cfg_legal(input logic [2:0] filter, input logic [2:0] stride);
        return (filter >= 3'd1) && (filter <= 3'd5) && (stride >= 3'd1) && (stride <= 3'd5);
    endfunction

endpackage

// File: rtl/pe_array_1d_ctrl_if.sv
// Weight, activation and result streams between the buffers and the sequencer.
interface pe_array_1d_ctrl_if #(
    parameter int LEN_W = 10
) ();
    import pe_array_pkg::*;

    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  a_valid;
    logic                  a_ready;
    logic [DATA_WIDTH-1:0] a_data;
    logic                  res_valid;
    logic [DATA_WIDTH-1:0] res_data;
    logic [LEN_W-1:0]      res_idx;

    modport master (
        output w_valid, w_data, a_valid, a_data,
        input  w_ready, a_ready, res_valid, res_data, res_idx
    );

    modport slave (
        input  w_valid, w_data, a_valid, a_data,
        output w_ready, a_ready, res_valid, res_data, res_idx
    );

endinterface

// File: rtl/pe_array_1d_ctrl_tag.sv
// Delay line carrying the "this is a real window" tag alongside the array pipeline.
module pe_tag_delay #(
    parameter int DEPTH = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic tag_in,
    output logic tag_out
);

    logic [DEPTH-1:0] sr;

    // Shift one stage per cycle; flush drops anything in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else if (flush) begin
            sr <= '0;
        end else begin
            sr <= (sr << 1) | DEPTH'(tag_in);
        end
    end

    assign tag_out = sr[DEPTH-1];

endmodule

// File: rtl/pe_array_1d_ctrl.sv
// Job sequencer for the 5-PE FP16 conv1d array: loads taps, streams
// activations, tags strided windows and emits them as results.
//
// state  | meaning
// IDLE   | waiting for a legal start
// LOAD_W | accepting `filter` tap words
// STREAM | one activation index per cycle, never stalls
// DRAIN  | pipeline empties, then done
module pe_array_1d_ctrl
    import pe_array_pkg::*;
#(
    parameter int LEN_W    = 10,
    parameter int PIPE_LAT = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [2:0]                     cfg_filter,
    input  logic [2:0]                     cfg_stride,
    input  logic [LEN_W-1:0]               cfg_len,
    output logic                           busy,
    output logic                           done,
    output logic                           err_cfg,
    output logic                           err_underrun,
    pe_array_1d_ctrl_if.slave              bus,
    output logic [DATA_WIDTH-1:0]          arr_a,
    output logic [MAX_TAPS*DATA_WIDTH-1:0] arr_b,
    output logic [2:0]                     arr_filter,
    output logic [2:0]                     arr_stride,
    input  logic [DATA_WIDTH-1:0]          arr_out
);

    // Drain covers the array latency plus the tag register and result register.
    localparam int                DRAIN_W    = $clog2(PIPE_LAT + 2);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_LAT + 1);

    state_t                 state;
    logic [2:0]             tap_idx;
    logic [2:0]             warm;
    logic [2:0]             phase;
    logic [LEN_W-1:0]       remain;
    logic [LEN_W-1:0]       res_cnt;
    logic [DRAIN_W-1:0]     drain_cnt;
    logic                   w_ready_q;
    logic                   a_ready_q;
    logic                   arr_tag;
    logic                   tag_out;
    logic                   res_valid_q;
    logic [DATA_WIDTH-1:0]  res_data_q;
    logic [LEN_W-1:0]       res_idx_q;
    logic                   start_ok;
    logic                   w_fire;
    logic                   tag_now;

    assign start_ok = (state == IDLE) && start && cfg_legal(cfg_filter, cfg_stride)
                      && (cfg_len >= LEN_W'(cfg_filter));
    assign w_fire   = w_ready_q && bus.w_valid;
    // warm counts off the first filter-1 indices, phase then marks every stride-th.
    assign tag_now  = (state == STREAM) && (warm == 3'd0) && (phase == 3'd0);

    // Sequencer FSM with all control outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_cfg      <= 1'b0;
            err_underrun <= 1'b0;
            w_ready_q    <= 1'b0;
            a_ready_q    <= 1'b0;
            arr_a        <= '0;
            arr_b        <= '0;
            arr_filter   <= '0;
            arr_stride   <= '0;
            arr_tag      <= 1'b0;
            tap_idx      <= '0;
            warm         <= '0;
            phase        <= '0;
            remain       <= '0;
            drain_cnt    <= '0;
        end else begin
            done    <= 1'b0;
            err_cfg <= 1'b0;
            arr_a   <= ZERO;
            arr_tag <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        arr_filter   <= cfg_filter;
                        arr_stride   <= cfg_stride;
                        remain       <= cfg_len;
                        warm         <= cfg_filter - 3'd1;
                        phase        <= 3'd0;
                        tap_idx      <= 3'd0;
                        arr_b        <= '0;
                        err_underrun <= 1'b0;
                        busy         <= 1'b1;
                        w_ready_q    <= 1'b1;
                        state        <= LOAD_W;
                    end else if (start) begin
                        err_cfg <= 1'b1;
                    end
                end
                LOAD_W: begin
                    if (w_fire) begin
                        arr_b[int'(tap_idx)*DATA_WIDTH +: DATA_WIDTH] <= bus.w_data;
                        if (tap_idx == arr_filter - 3'd1) begin
                            w_ready_q <= 1'b0;
                            a_ready_q <= 1'b1;
                            state     <= STREAM;
                        end else begin
                            tap_idx <= tap_idx + 3'd1;
                        end
                    end
                end
                STREAM: begin
                    arr_a   <= bus.a_valid ? bus.a_data : ZERO;
                    arr_tag <= tag_now;
                    if (!bus.a_valid) begin
                        err_underrun <= 1'b1;
                    end
                    if (warm != 3'd0) begin
                        warm <= warm - 3'd1;
                    end else if (phase == 3'd0) begin
                        phase <= arr_stride - 3'd1;
                    end else begin
                        phase <= phase - 3'd1;
                    end
                    if (remain == LEN_W'(1)) begin
                        a_ready_q <= 1'b0;
                        drain_cnt <= DRAIN_LOAD;
                        state     <= DRAIN;
                    end else begin
                        remain <= remain - LEN_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    pe_tag_delay #(.DEPTH(PIPE_LAT)) u_tag_delay (
        .clk     (clk),
        .reset   (reset),
        .flush   (start_ok),
        .tag_in  (arr_tag),
        .tag_out (tag_out)
    );

    // Capture the array output whenever a tagged window emerges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            res_cnt     <= '0;
        end else begin
            res_valid_q <= tag_out;
            res_data_q  <= tag_out ? arr_out : ZERO;
            if (start_ok) begin
                res_cnt <= '0;
            end else if (tag_out) begin
                res_idx_q <= res_cnt;
                res_cnt   <= res_cnt + LEN_W'(1);
            end
        end
    end

    assign bus.w_ready   = w_ready_q;
    assign bus.a_ready   = a_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_idx   = res_idx_q;

endmodule

// File: tb/tb_pe_array_1d_ctrl.sv
// Directed bench for pe_array_1d_ctrl with a behavioural model of the PE array.
module tb_pe_array_1d_ctrl;
    import pe_array_pkg::*;

    localparam int LEN_W    = 10;
    localparam int PIPE_LAT = 6;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  cfg_filter;
    logic [2:0]  cfg_stride;
    logic [9:0]  cfg_len;
    logic        busy, done, err_cfg, err_underrun;
    logic [15:0] arr_a;
    logic [79:0] arr_b;
    logic [2:0]  arr_filter, arr_stride;
    logic [15:0] arr_out;

    pe_array_1d_ctrl_if #(.LEN_W(LEN_W)) bus ();

    pe_array_1d_ctrl #(.LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_filter   (cfg_filter),
        .cfg_stride   (cfg_stride),
        .cfg_len      (cfg_len),
        .busy         (busy),
        .done         (done),
        .err_cfg      (err_cfg),
        .err_underrun (err_underrun),
        .bus          (bus),
        .arr_a        (arr_a),
        .arr_b        (arr_b),
        .arr_filter   (arr_filter),
        .arr_stride   (arr_stride),
        .arr_out      (arr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Small FP16 table covering the values the directed jobs produce.
    function automatic int fp_val(input logic [15:0] f);
        case (f)
            16'h3C00: return 1;
            16'h4000: return 2;
            16'h4200: return 3;
            16'h4400: return 4;
            16'h4500: return 5;
            default:  return 0;
        endcase
    endfunction

    function automatic logic [15:0] fp_enc(input int v);
        case (v)
            0:       return 16'h0000;
            1:       return 16'h3C00;
            2:       return 16'h4000;
            3:       return 16'h4200;
            4:       return 16'h4400;
            5:       return 16'h4500;
            6:       return 16'h4600;
            default: return 16'hFFFF;
        endcase
    endfunction

    // PE array model: window sum of the last `filter` arr_a words, PIPE_LAT cycles later.
    logic [15:0] a_hist [0:4];
    logic [15:0] sum_pipe [0:PIPE_LAT];
    initial begin
        for (int k = 0; k < 5; k++) a_hist[k] = '0;
        for (int k = 0; k <= PIPE_LAT; k++) sum_pipe[k] = '0;
        arr_out = '0;
    end
    always @(posedge clk) begin
        int s;
        #1;
        for (int k = 4; k > 0; k--) a_hist[k] = a_hist[k-1];
        a_hist[0] = arr_a;
        s = 0;
        for (int k = 0; k < int'(arr_filter) && k < 5; k++)
            s += fp_val(arr_b[k*16 +: 16]) * fp_val(a_hist[int'(arr_filter) - 1 - k]);
        for (int k = PIPE_LAT; k > 0; k--) sum_pipe[k] = sum_pipe[k-1];
        sum_pipe[0] = fp_enc(s);
        arr_out = sum_pipe[PIPE_LAT];
    end

    // Result collector, sampled mid-cycle.
    logic [15:0] got_d [$];
    logic [9:0]  got_i [$];
    logic [15:0] exp_q [$];
    int last_res_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int viol = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.res_valid) begin
            got_d.push_back(bus.res_data);
            got_i.push_back(bus.res_idx);
            last_res_cyc = cyc;
            if (!busy) viol++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input string name, input logic [2:0] f, input logic [2:0] s,
                           input logic [9:0] l, input logic [15:0] tap, input int drop,
                           input logic exp_ur);
        int k;
        int n;
        got_d.delete();
        got_i.delete();
        done_cnt = 0;
        viol = 0;
        cfg_filter = f;
        cfg_stride = s;
        cfg_len = l;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, " busy_on"}, 64'(busy), 64'd1);
        check({name, " w_ready_on"}, 64'(bus.w_ready), 64'd1);
        k = 0;
        n = 0;
        while (k < int'(f) && n < 20) begin
            bus.w_valid = 1'b1;
            bus.w_data = tap;
            if (bus.w_ready) k++;
            @(posedge clk); #1;
            n++;
        end
        bus.w_valid = 1'b0;
        bus.w_data = '0;
        check({name, " w_count"}, 64'(k), 64'(f));
        check({name, " a_ready_on"}, 64'(bus.a_ready), 64'd1);
        for (int i = 0; i < int'(l); i++) begin
            bus.a_valid = (i != drop);
            bus.a_data = ONE;
            @(posedge clk); #1;
            if (i == drop) check({name, " arr_a_zero"}, 64'(arr_a), 64'h0);
            else if (i == 0) check({name, " arr_a_first"}, 64'(arr_a), 64'h3C00);
        end
        bus.a_valid = 1'b0;
        bus.a_data = '0;
        n = 0;
        while (done_cnt == 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " done_seen"}, 64'(done_cnt), 64'd1);
        check({name, " res_count"}, 64'(got_d.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s res_data[%0d]", name, i), 64'(got_d[i]), 64'(exp_q[i]));
            check($sformatf("%s res_idx[%0d]", name, i), 64'(got_i[i]), 64'(i));
        end
        check({name, " done_after_last"}, 64'(done_cyc), 64'(last_res_cyc + 1));
        check({name, " busy_off"}, 64'(busy), 64'd0);
        check({name, " res_in_idle"}, 64'(viol), 64'd0);
        check({name, " err_underrun"}, 64'(err_underrun), 64'(exp_ur));
    endtask

    task automatic cfg_reject(input string name, input logic [2:0] f, input logic [2:0] s,
                              input logic [9:0] l);
        cfg_filter = f;
        cfg_stride = s;
        cfg_len = l;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, " err_cfg"}, 64'(err_cfg), 64'd1);
        check({name, " busy"}, 64'(busy), 64'd0);
        check({name, " w_ready"}, 64'(bus.w_ready), 64'd0);
        @(posedge clk); #1;
        check({name, " err_cfg_pulse"}, 64'(err_cfg), 64'd0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        cfg_filter = '0;
        cfg_stride = '0;
        cfg_len = '0;
        bus.w_valid = 1'b0;
        bus.w_data = '0;
        bus.a_valid = 1'b0;
        bus.a_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst arr_a", 64'(arr_a), 64'd0);
        check("rst arr_b_lo", arr_b[63:0], 64'd0);
        check("rst w_ready", 64'(bus.w_ready), 64'd0);
        check("rst res_valid", 64'(bus.res_valid), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // filter=3 stride=1 len=8: six windows of 3.0
        exp_q = '{16'h4200, 16'h4200, 16'h4200, 16'h4200, 16'h4200, 16'h4200};
        run_job("f3s1", 3'd3, 3'd1, 10'd8, ONE, -1, 1'b0);
        check("f3s1 arr_filter", 64'(arr_filter), 64'd3);

        // filter=5 stride=2 len=9: windows at 4, 6, 8
        exp_q = '{16'h4500, 16'h4500, 16'h4500};
        run_job("f5s2", 3'd5, 3'd2, 10'd9, ONE, -1, 1'b0);
        for (int k = 0; k < 5; k++)
            check($sformatf("f5s2 arr_b[%0d]", k), 64'(arr_b[k*16 +: 16]), 64'h3C00);
        check("f5s2 arr_stride", 64'(arr_stride), 64'd2);

        // filter=1 len=1 with tap 2.0
        exp_q = '{16'h4000};
        run_job("f1s1", 3'd1, 3'd1, 10'd1, 16'h4000, -1, 1'b0);
        check("f1s1 arr_b tap1", 64'(arr_b[15:0]), 64'h4000);
        check("f1s1 arr_b upper", arr_b[79:16], 64'h0);

        cfg_reject("rej_f6", 3'd6, 3'd1, 10'd8);
        cfg_reject("rej_s0", 3'd3, 3'd0, 10'd8);
        cfg_reject("rej_len", 3'd3, 3'd1, 10'd2);

        // a_valid dropped at index 4
        exp_q = '{16'h4000, 16'h4000, 16'h4000, 16'h3C00, 16'h3C00};
        run_job("underrun", 3'd2, 3'd1, 10'd6, ONE, 4, 1'b1);

        // reset mid-stream
        got_d.delete();
        got_i.delete();
        done_cnt = 0;
        cfg_filter = 3'd3;
        cfg_stride = 3'd1;
        cfg_len = 10'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.w_valid = 1'b1;
        bus.w_data = ONE;
        repeat (3) begin @(posedge clk); #1; end
        bus.w_valid = 1'b0;
        bus.a_valid = 1'b1;
        bus.a_data = ONE;
        repeat (4) begin @(posedge clk); #1; end
        check("midrst a_ready_pre", 64'(bus.a_ready), 64'd1);
        check("midrst arr_a_pre", 64'(arr_a), 64'h3C00);
        reset = 1'b0;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst arr_a", 64'(arr_a), 64'd0);
        check("midrst arr_b", arr_b[63:0], 64'd0);
        check("midrst arr_filter", 64'(arr_filter), 64'd0);
        check("midrst a_ready", 64'(bus.a_ready), 64'd0);
        check("midrst res_valid", 64'(bus.res_valid), 64'd0);
        bus.a_valid = 1'b0;
        bus.a_data = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        check("midrst no_results", 64'(got_d.size()), 64'd0);
        check("midrst no_done", 64'(done_cnt), 64'd0);

        exp_q = '{16'h4200, 16'h4200, 16'h4200, 16'h4200, 16'h4200, 16'h4200};
        run_job("after_rst", 3'd3, 3'd1, 10'd8, ONE, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
